// File: rtl/max7219_rx_pkg.sv
// +----------------------------------------------------------------------+
// | max7219_rx_pkg                                                       |
// | Shared frame size, register address map and FSM encoding.            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package max7219_rx_pkg;

  localparam int FRAME_SIZE = 16;

  localparam logic [3:0] ADDR_NOOP      = 4'h0;
  localparam logic [3:0] ADDR_DIGIT0    = 4'h1;
  localparam logic [3:0] ADDR_DIGIT1    = 4'h2;
  localparam logic [3:0] ADDR_DIGIT2    = 4'h3;
  localparam logic [3:0] ADDR_DIGIT3    = 4'h4;
  localparam logic [3:0] ADDR_DIGIT4    = 4'h5;
  localparam logic [3:0] ADDR_DIGIT5    = 4'h6;
  localparam logic [3:0] ADDR_DIGIT6    = 4'h7;
  localparam logic [3:0] ADDR_DIGIT7    = 4'h8;
  localparam logic [3:0] ADDR_DECODE    = 4'h9;
  localparam logic [3:0] ADDR_INTENSITY = 4'hA;
  localparam logic [3:0] ADDR_SCANLIM   = 4'hB;
  localparam logic [3:0] ADDR_SHUTDOWN  = 4'hC;
  localparam logic [3:0] ADDR_TEST      = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RECV   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/max7219_rx_sync_edge.sv
// +----------------------------------------------------------------------+
// | sync_edge                                                            |
// | Multi-flop synchronizer with rise/fall detection on the last stage.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  // STAGES must be at least 2 for metastability settling.
  logic [STAGES-1:0] r_sync;
  logic              r_dly;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync <= {STAGES{RST_VAL}};
      r_dly  <= RST_VAL;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_async};
      r_dly  <= r_sync[STAGES-1];
    end
  end

  assign o_level = r_sync[STAGES-1];
  assign o_rise  = r_sync[STAGES-1] & ~r_dly;
  assign o_fall  = ~r_sync[STAGES-1] & r_dly;

endmodule

`default_nettype wire

// File: rtl/max7219_rx.sv
// +----------------------------------------------------------------------+
// | max7219_rx                                                           |
// | SPI slave receiving MAX7219-style frames into a register file.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module max7219_rx #(
  parameter int FRAME_SIZE  = max7219_rx_pkg::FRAME_SIZE,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_sclk,
  input  logic       i_cs_n,
  input  logic       i_din,
  output logic       o_frame_valid,
  output logic [3:0] o_frame_addr,
  output logic [7:0] o_frame_data,
  output logic       o_frame_err,
  input  logic [2:0] i_row_sel,
  output logic [7:0] o_row_data,
  output logic [7:0] o_decode_mode,
  output logic [3:0] o_intensity,
  output logic [2:0] o_scan_limit,
  output logic       o_shutdown_n,
  output logic       o_disp_test
);

  import max7219_rx_pkg::*;

  localparam logic [4:0] C_CNT_FULL = 5'(FRAME_SIZE);
  localparam logic [4:0] C_CNT_SAT  = 5'(FRAME_SIZE + 1);

  logic w_sclk_lvl, w_sclk_rise, w_sclk_fall;
  logic w_cs_lvl, w_cs_rise, w_cs_fall;
  logic w_din, w_din_rise, w_din_fall;

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .i_async(i_sclk),
    .o_level(w_sclk_lvl), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .i_async(i_cs_n),
    .o_level(w_cs_lvl), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_din (
    .clk(clk), .rst_n(rst_n), .i_async(i_din),
    .o_level(w_din), .o_rise(w_din_rise), .o_fall(w_din_fall)
  );

  state_t                r_state;
  logic [FRAME_SIZE-1:0] r_shift;
  logic [4:0]            r_cnt;
  logic                  r_frame_valid;
  logic                  r_frame_err;
  logic [3:0]            r_frame_addr;
  logic [7:0]            r_frame_data;
  logic [7:0]            r_digit [8];
  logic [7:0]            r_decode;
  logic [3:0]            r_intensity;
  logic [2:0]            r_scan_limit;
  logic                  r_shutdown_n;
  logic                  r_disp_test;

  logic [3:0] w_addr;
  logic [7:0] w_data;
  logic       w_unused;

  assign w_addr   = r_shift[11:8];
  assign w_data   = r_shift[7:0];
  assign w_unused = ^{w_sclk_lvl, w_sclk_fall, w_cs_lvl, w_din_rise, w_din_fall,
                      r_shift[FRAME_SIZE-1:12]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_shift       <= '0;
      r_cnt         <= '0;
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
      r_frame_addr  <= '0;
      r_frame_data  <= '0;
      for (int i = 0; i < 8; i++) r_digit[i] <= '0;
      r_decode      <= '0;
      r_intensity   <= '0;
      r_scan_limit  <= '0;
      r_shutdown_n  <= 1'b0;
      r_disp_test   <= 1'b0;
    end else begin
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_cs_fall) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_state <= ST_RECV;
          end
        end
        ST_RECV: begin
          // A deselect wins over a coincident sclk edge.
          if (w_cs_rise) begin
            r_state <= ST_COMMIT;
          end else if (w_sclk_rise) begin
            r_shift <= {r_shift[FRAME_SIZE-2:0], w_din};
            if (r_cnt != C_CNT_SAT) r_cnt <= r_cnt + 5'd1;
          end
        end
        ST_COMMIT: begin
          r_state <= ST_IDLE;
          if (r_cnt == C_CNT_FULL) begin
            r_frame_valid <= 1'b1;
            r_frame_addr  <= w_addr;
            r_frame_data  <= w_data;
            case (w_addr)
              ADDR_DIGIT0, ADDR_DIGIT1, ADDR_DIGIT2, ADDR_DIGIT3,
              ADDR_DIGIT4, ADDR_DIGIT5, ADDR_DIGIT6, ADDR_DIGIT7:
                r_digit[3'(w_addr - ADDR_DIGIT0)] <= w_data;
              ADDR_DECODE:    r_decode     <= w_data;
              ADDR_INTENSITY: r_intensity  <= w_data[3:0];
              ADDR_SCANLIM:   r_scan_limit <= w_data[2:0];
              ADDR_SHUTDOWN:  r_shutdown_n <= w_data[0];
              ADDR_TEST:      r_disp_test  <= w_data[0];
              ADDR_NOOP:      ;
              default:        ;
            endcase
          end else begin
            r_frame_err <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_frame_valid = r_frame_valid;
  assign o_frame_err   = r_frame_err;
  assign o_frame_addr  = r_frame_addr;
  assign o_frame_data  = r_frame_data;
  assign o_row_data    = r_digit[i_row_sel];
  assign o_decode_mode = r_decode;
  assign o_intensity   = r_intensity;
  assign o_scan_limit  = r_scan_limit;
  assign o_shutdown_n  = r_shutdown_n;
  assign o_disp_test   = r_disp_test;

endmodule

`default_nettype wire

// File: doc/max7219_rx.md
MAX7219_RX -- requirements
Module: max7219_rx

Interface
REQ-001 Parameter FRAME_SIZE, default 16, number of bits per SPI frame.
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer flops on each SPI input (minimum 2).
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 sclk  input  1  SPI serial clock, asynchronous to clk.
REQ-006 cs_n  input  1  SPI chip select, active-low, asynchronous to clk.
REQ-007 din  input  1  SPI serial data, MSB first, asynchronous to clk.
REQ-008 frame_valid  output  1  one-cycle pulse marking a correctly sized frame.
REQ-009 frame_addr  output  4  bits [11:8] of the last valid frame.
REQ-010 frame_data  output  8  bits [7:0] of the last valid frame.
REQ-011 frame_err  output  1  one-cycle pulse marking a frame with a bit count other than FRAME_SIZE.
REQ-012 row_sel  input  3  digit register readback index (0 selects digit 0 at address 0x1).
REQ-013 row_data  output  8  combinational readback of the digit register selected by row_sel.
REQ-014 decode_mode  output  8  register 0x9.
REQ-015 intensity  output  4  register 0xA, bits [3:0].
REQ-016 scan_limit  output  3  register 0xB, bits [2:0].
REQ-017 shutdown_n  output  1  register 0xC, bit 0.
REQ-018 disp_test  output  1  register 0xF, bit 0.

Function
REQ-019 sclk, cs_n and din shall each pass through a SYNC_STAGES flop synchronizer; edge detection shall use the last synchronized stage and one further delay flop.
REQ-020 The FSM shall have three states: IDLE, RECV and COMMIT.
REQ-021 IDLE: a falling edge on synchronized cs_n shall clear the shift register and the bit counter and enter RECV.
REQ-022 RECV: each rising edge on synchronized sclk shall shift synchronized din into the LSB of a FRAME_SIZE-bit shift register and increment the bit counter.
REQ-023 The bit counter shall be 5 bits wide and saturate at FRAME_SIZE+1; shifting continues after saturation, so the register holds the last FRAME_SIZE bits.
REQ-024 RECV: a rising edge on synchronized cs_n shall enter COMMIT; any sclk edge detected in the same cycle shall be ignored.
REQ-025 COMMIT, bit count == FRAME_SIZE: pulse frame_valid, update frame_addr and frame_data, and write the decoded register; then return to IDLE.
REQ-026 COMMIT, bit count != FRAME_SIZE (including zero): pulse frame_err, leave all registers and frame_addr/frame_data unchanged, and return to IDLE.
REQ-027 Address decode: 0x0 is a no-op; 0x1-0x8 write digit 0-7; 0x9-0xC and 0xF write their registers; 0xD and 0xE are ignored. frame_valid shall still pulse for every ignored or no-op address.
REQ-028 Latency: frame_valid and the register update shall appear SYNC_STAGES+2 clk cycles after the cs_n pin rises.
REQ-029 Sampling requires sclk high and low phases each of at least SYNC_STAGES+1 clk periods; faster sclk is out of specification.
REQ-030 sclk edges in IDLE shall have no effect.
REQ-031 frame_valid and frame_err shall never be asserted in the same cycle.

Reset
REQ-032 While rst_n is low at a clk edge: FSM goes to IDLE; counter, shift register, synchronizers and edge flops are cleared (cs_n synchronizer flops set to 1).
REQ-033 Output reset values: frame_valid=0, frame_err=0, frame_addr=0, frame_data=0, all digits=0, decode_mode=0, intensity=0, scan_limit=0, shutdown_n=0, disp_test=0.
REQ-034 Reset asserted mid-frame shall discard the partial frame without any pulse; after release, the block shall wait for a fresh cs_n falling edge.

Structure
REQ-035 A shared package shall hold FRAME_SIZE and the address constants ADDR_NOOP, ADDR_DIGIT0 through ADDR_DIGIT7, ADDR_DECODE, ADDR_INTENSITY, ADDR_SCANLIM, ADDR_SHUTDOWN and ADDR_TEST, plus the FSM state encoding.
REQ-036 One sub-module, sync_edge, shall contain the synchronizer and the rise/fall detector, instanced three times.

Verification
REQ-037 Send frame 0x0A05 with sclk at 8 clk periods per bit -> one frame_valid, frame_addr=0xA, frame_data=0x05, intensity=5, exactly SYNC_STAGES+2 cycles after cs_n rises.
REQ-038 Send frames 0x0155 through 0x08AA (8 digit writes) -> row_sel 0..7 returns the written bytes; decode_mode stays 0.
REQ-039 Send 15-bit and 17-bit frames addressed to 0x0C01 -> frame_err pulses each time; shutdown_n stays 0; no frame_valid.
REQ-040 Send frames 0x0000, 0x0D12 and 0x0E34 -> frame_valid pulses three times; no register changes.
REQ-041 Assert rst_n low after 8 bits of 0x0F01, release it, then send a full 0x0F01 -> no pulse for the partial frame; disp_test=1 after the full frame.
REQ-042 Toggle sclk with cs_n high, then pulse cs_n low/high with no sclk -> no state change; frame_err pulses once (zero bits).
